// File: rtl/hps_mailbox_pkg.sv
// Register map, STATUS layout and error-source encoding shared by the
// mailbox top and its bench.
package hps_mailbox_pkg;

  localparam logic [7:0] REG_TX_DATA   = 8'h00;
  localparam logic [7:0] REG_TX_START  = 8'h04;
  localparam logic [7:0] REG_STATUS    = 8'h08;
  localparam logic [7:0] REG_RX_DATA   = 8'h0C;
  localparam logic [7:0] REG_IRQ_PEND  = 8'h10;
  localparam logic [7:0] REG_IRQ_MASK  = 8'h14;
  localparam logic [7:0] REG_IRQ_FORCE = 8'h18;
  localparam logic [7:0] REG_ERR_CLR   = 8'h1C;
  localparam logic [7:0] REG_CFG_BASE  = 8'h20;

  localparam int STATUS_ERR_BIT      = 0;
  localparam int STATUS_TX_READY_BIT = 1;
  localparam int STATUS_RX_LEVEL_LSB = 8;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_TX_BUSY  = 2'd1,
    ERR_RX_EMPTY = 2'd2
  } err_src_e;

  function automatic logic [7:0] cfg_offset(input int k);
    return REG_CFG_BASE + 8'(k * 4);
  endfunction

endpackage

// File: rtl/hps_irq_ctrl.sv
// Interrupt edge capture, pending/mask registers and registered irq output.
module hps_irq_ctrl #(
  parameter int IRQ_N = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IRQ_N-1:0] irq_src,
  input  logic [IRQ_N-1:0] pend_clr,
  input  logic [IRQ_N-1:0] pend_force,
  input  logic             mask_we,
  input  logic [IRQ_N-1:0] mask_wdata,
  output logic [IRQ_N-1:0] pend,
  output logic [IRQ_N-1:0] mask,
  output logic             irq
);

  logic [IRQ_N-1:0] src_q;
  logic [IRQ_N-1:0] rise;

  assign rise = irq_src & ~src_q;

  // src_q tracks irq_src even in reset so levels held across release are not edges
  always_ff @(posedge clk) begin
    src_q <= irq_src;
    if (reset) begin
      pend <= '0;
      mask <= '0;
      irq  <= 1'b0;
    end else begin
      pend <= (pend & ~pend_clr) | rise | pend_force;
      if (mask_we)
        mask <= mask_wdata;
      irq <= |(pend & mask);
    end
  end

endmodule

// File: rtl/hps_mailbox.sv
// HPS-facing mailbox: TX/RX FIFO strobes, sticky error, interrupt block and
// config registers behind a registered-read slave port.
module hps_mailbox
  import hps_mailbox_pkg::*;
#(
  parameter int                   DATA_W   = 8,
  parameter int                   IRQ_N    = 4,
  parameter int                   CFG_N    = 4,
  parameter logic [CFG_N*32-1:0]  CFG_INIT = {4{32'd0}}
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          address,
  input  logic                chipselect,
  input  logic                read_en,
  input  logic                write_en,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  output logic [DATA_W-1:0]   tx_data,
  output logic                tx_wren,
  input  logic                tx_ready,
  output logic                tx_start,
  input  logic [DATA_W-1:0]   rx_data,
  output logic                rx_rden,
  input  logic [7:0]          rx_level,
  input  logic [IRQ_N-1:0]    irq_src,
  output logic                irq,
  output logic [CFG_N*32-1:0] cfg
);

  logic [7:0]       addr_w;
  logic             addr_lsb_unused;
  logic             wr_acc, rd_acc, rd_wr_clash;
  logic             err, err_clr;
  err_src_e         err_src;
  logic [31:0]      status_word, rd_val;
  logic [IRQ_N-1:0] pend, mask, pend_clr, pend_force;
  logic             mask_we;

  assign addr_w          = {address[7:2], 2'b00};
  assign addr_lsb_unused = ^address[1:0];

  // a simultaneous read+write strobe is treated purely as a write
  assign wr_acc      = chipselect & write_en;
  assign rd_acc      = chipselect & read_en & ~write_en;
  assign rd_wr_clash = chipselect & read_en & write_en;

  assign err_clr    = wr_acc && (addr_w == REG_ERR_CLR) && writedata[0];
  assign pend_clr   = (wr_acc && addr_w == REG_IRQ_PEND)  ? writedata[IRQ_N-1:0] : '0;
  assign pend_force = (wr_acc && addr_w == REG_IRQ_FORCE) ? writedata[IRQ_N-1:0] : '0;
  assign mask_we    = wr_acc && (addr_w == REG_IRQ_MASK);

  always_comb begin
    status_word = '0;
    status_word[STATUS_ERR_BIT]             = err;
    status_word[STATUS_TX_READY_BIT]        = tx_ready;
    status_word[STATUS_RX_LEVEL_LSB +: 8]   = rx_level;
  end

  always_comb begin
    rd_val  = '0;
    err_src = ERR_NONE;
    case (addr_w)
      REG_STATUS:   rd_val = status_word;
      REG_RX_DATA:  if (rx_level != 8'd0) rd_val = 32'(rx_data);
      REG_IRQ_PEND: rd_val = 32'(pend);
      REG_IRQ_MASK: rd_val = 32'(mask);
      default:      ;
    endcase
    for (int k = 0; k < CFG_N; k++)
      if (addr_w == cfg_offset(k))
        rd_val = cfg[k*32 +: 32];
    if (wr_acc && addr_w == REG_TX_START && writedata[0] && !tx_ready)
      err_src = ERR_TX_BUSY;
    else if (rd_acc && addr_w == REG_RX_DATA && rx_level == 8'd0)
      err_src = ERR_RX_EMPTY;
  end

  // reset also cancels any strobe the previous access would have produced
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
      tx_data  <= '0;
      tx_wren  <= 1'b0;
      tx_start <= 1'b0;
      rx_rden  <= 1'b0;
      err      <= 1'b0;
      cfg      <= CFG_INIT;
    end else begin
      tx_wren  <= wr_acc && (addr_w == REG_TX_DATA);
      if (wr_acc && addr_w == REG_TX_DATA)
        tx_data <= writedata[DATA_W-1:0];
      tx_start <= wr_acc && (addr_w == REG_TX_START) && writedata[0] && tx_ready;
      rx_rden  <= rd_acc && (addr_w == REG_RX_DATA) && (rx_level != 8'd0);
      err      <= (err_src != ERR_NONE) || (err && !err_clr);
      if (rd_acc)
        readdata <= rd_val;
      else if (rd_wr_clash)
        readdata <= '0;
      for (int k = 0; k < CFG_N; k++)
        if (wr_acc && addr_w == cfg_offset(k))
          cfg[k*32 +: 32] <= writedata;
    end
  end

  hps_irq_ctrl #(.IRQ_N(IRQ_N)) u_irq (
    .clk        (clk),
    .reset      (reset),
    .irq_src    (irq_src),
    .pend_clr   (pend_clr),
    .pend_force (pend_force),
    .mask_we    (mask_we),
    .mask_wdata (writedata[IRQ_N-1:0]),
    .pend       (pend),
    .mask       (mask),
    .irq        (irq)
  );

endmodule

// File: tb/tb_hps_mailbox.sv
// Directed bench for hps_mailbox: bus accesses, FIFO strobes, err, irq, cfg.
module tb_hps_mailbox;

  localparam logic [127:0] INIT = {32'hDEAD0003, 32'h00000002, 32'h12345678, 32'hCAFEF00D};

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   address;
  logic         chipselect, read_en, write_en;
  logic [31:0]  writedata, readdata;
  logic [7:0]   tx_data;
  logic         tx_wren, tx_ready, tx_start;
  logic [7:0]   rx_data;
  logic         rx_rden;
  logic [7:0]   rx_level;
  logic [3:0]   irq_src;
  logic         irq;
  logic [127:0] cfg;

  int checks = 0;
  int errors = 0;
  logic [31:0] rd;

  hps_mailbox #(.DATA_W(8), .IRQ_N(4), .CFG_N(4), .CFG_INIT(INIT)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .read_en    (read_en),
    .write_en   (write_en),
    .writedata  (writedata),
    .readdata   (readdata),
    .tx_data    (tx_data),
    .tx_wren    (tx_wren),
    .tx_ready   (tx_ready),
    .tx_start   (tx_start),
    .rx_data    (rx_data),
    .rx_rden    (rx_rden),
    .rx_level   (rx_level),
    .irq_src    (irq_src),
    .irq        (irq),
    .cfg        (cfg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Access is driven for one cycle; returns at the negedge after the capturing edge.
  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_en = 1'b1; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_en = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; read_en = 1'b1; address = a;
    @(negedge clk);
    chipselect = 1'b0; read_en = 1'b0;
    d = readdata;
  endtask

  initial begin
    reset = 1'b1; address = '0; chipselect = 1'b0; read_en = 1'b0; write_en = 1'b0;
    writedata = '0; tx_ready = 1'b0; rx_data = '0; rx_level = '0; irq_src = 4'hF;
    repeat (3) @(negedge clk);
    check("rst_readdata", readdata, 32'h0);
    check("rst_tx_wren", 32'(tx_wren), 32'h0);
    check("rst_tx_start", 32'(tx_start), 32'h0);
    check("rst_rx_rden", 32'(rx_rden), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // sources high through reset release leave nothing pending; cfg from init
    bus_read(8'h10, rd);
    check("rst_pend_zero", rd, 32'h0);
    for (int k = 0; k < 4; k++)
      check("cfg_init", cfg[k*32 +: 32], INIT[k*32 +: 32]);
    bus_write(8'h24, 32'h11223344);
    bus_read(8'h24, rd);
    check("cfg1_readback", rd, 32'h11223344);
    check("cfg1_port", cfg[63:32], 32'h11223344);
    bus_read(8'h2C, rd);
    check("cfg3_read_init", rd, 32'hDEAD0003);
    irq_src = 4'h0;

    // TX data push
    bus_write(8'h00, 32'h1A5);
    check("tx_data", 32'(tx_data), 32'hA5);
    check("tx_wren_hi", 32'(tx_wren), 32'h1);
    @(negedge clk);
    check("tx_wren_lo", 32'(tx_wren), 32'h0);

    // TX start while busy -> err; then clear and start while ready
    bus_write(8'h04, 32'h1);
    check("tx_start_busy", 32'(tx_start), 32'h0);
    bus_read(8'h08, rd);
    check("status_err", rd, 32'h1);
    bus_write(8'h1C, 32'h1);
    tx_ready = 1'b1;
    bus_write(8'h04, 32'h1);
    check("tx_start_hi", 32'(tx_start), 32'h1);
    @(negedge clk);
    check("tx_start_lo", 32'(tx_start), 32'h0);
    bus_read(8'h08, rd);
    check("status_ready", rd, 32'h2);

    // RX pop with data, then with empty FIFO
    rx_level = 8'd3; rx_data = 8'h5C;
    bus_read(8'h0C, rd);
    check("rx_data", rd, 32'h5C);
    check("rx_rden_hi", 32'(rx_rden), 32'h1);
    @(negedge clk);
    check("rx_rden_lo", 32'(rx_rden), 32'h0);
    rx_level = 8'd0;
    bus_read(8'h0C, rd);
    check("rx_empty_data", rd, 32'h0);
    check("rx_empty_rden", 32'(rx_rden), 32'h0);
    bus_read(8'h08, rd);
    check("status_rx_err", rd, 32'h3);
    rx_level = 8'h07;
    bus_read(8'h08, rd);
    check("status_level", rd, 32'h0703);

    // edge recorded while masked, then unmask and clear
    @(negedge clk);
    irq_src = 4'b0100;
    repeat (2) @(negedge clk);
    bus_read(8'h10, rd);
    check("pend_edge2", rd, 32'h4);
    check("irq_masked", 32'(irq), 32'h0);
    bus_write(8'h14, 32'h4);
    check("irq_mask_same", 32'(irq), 32'h0);
    @(negedge clk);
    check("irq_unmasked", 32'(irq), 32'h1);
    bus_write(8'h10, 32'h4);
    @(negedge clk);
    check("irq_cleared", 32'(irq), 32'h0);

    // edge on src[1] coincides with a clear of pend[1]: set wins
    @(negedge clk);
    irq_src = 4'b0110;
    chipselect = 1'b1; write_en = 1'b1; address = 8'h10; writedata = 32'h2;
    @(negedge clk);
    chipselect = 1'b0; write_en = 1'b0;
    bus_read(8'h10, rd);
    check("pend_set_wins", rd, 32'h2);

    // force, and clear with only out-of-range bits set
    bus_write(8'h18, 32'h9);
    bus_read(8'h10, rd);
    check("pend_force", rd, 32'hB);
    bus_write(8'h10, 32'hFFFFFFF0);
    bus_read(8'h10, rd);
    check("pend_hi_bits", rd, 32'hB);
    bus_read(8'h14, rd);
    check("mask_read", rd, 32'h4);
    check("irq_no_overlap", 32'(irq), 32'h0);

    // read+write together on RX_DATA: readdata zero, no pop
    rx_level = 8'd3;
    @(negedge clk);
    chipselect = 1'b1; read_en = 1'b1; write_en = 1'b1; address = 8'h0C; writedata = 32'hFF;
    @(negedge clk);
    chipselect = 1'b0; read_en = 1'b0; write_en = 1'b0;
    check("clash_readdata", readdata, 32'h0);
    check("clash_rden", 32'(rx_rden), 32'h0);

    // unmapped and write-only addresses read as zero
    bus_read(8'h14, rd);
    bus_read(8'h40, rd);
    check("unmapped_read", rd, 32'h0);
    bus_read(8'h14, rd);
    bus_read(8'h00, rd);
    check("wo_read", rd, 32'h0);

    // reset arriving with a TX_DATA write suppresses the pulse
    @(negedge clk);
    chipselect = 1'b1; write_en = 1'b1; address = 8'h00; writedata = 32'h33;
    reset = 1'b1;
    @(negedge clk);
    chipselect = 1'b0; write_en = 1'b0;
    check("rst_abort_wren", 32'(tx_wren), 32'h0);
    check("rst_cfg1", cfg[63:32], 32'h12345678);
    reset = 1'b0;
    @(negedge clk);
    bus_read(8'h10, rd);
    check("rst2_pend", rd, 32'h0);
    check("rst2_irq", 32'(irq), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hps_mailbox.md
HPS_MAILBOX -- requirements
Module: hps_mailbox

Interface
REQ-001 SHALL have parameter DATA_W, default 8, giving the TX/RX FIFO data width (1..32).
REQ-002 SHALL have parameter IRQ_N, default 4, giving the number of interrupt sources (1..16).
REQ-003 SHALL have parameter CFG_N, default 4, giving the number of 32-bit config registers (1..8).
REQ-004 SHALL have parameter CFG_INIT, default {4{32'd0}}, a flat CFG_N*32 vector of config reset values.
REQ-005 SHALL have ports as listed below:
- clk  in  1  sole clock, all logic on posedge.
- reset  in  1  synchronous, active-high.
- address  in  8  byte address; word aligned, bits[1:0] ignored.
- chipselect  in  1  qualifies read_en and write_en.
- read_en  in  1  read strobe.
- write_en  in  1  write strobe.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- tx_data  out  DATA_W  TX FIFO write data.
- tx_wren  out  1  TX FIFO push pulse.
- tx_ready  in  1  transmitter idle.
- tx_start  out  1  transmit start pulse.
- rx_data  in  DATA_W  RX FIFO head (show-ahead).
- rx_rden  out  1  RX FIFO pop pulse.
- rx_level  in  8  RX FIFO occupancy.
- irq_src  in  IRQ_N  interrupt sources, level inputs.
- irq  out  1  interrupt to HPS.
- cfg  out  CFG_N*32  config registers, flat vector, cfg[k] = bits[32k+31:32k].

Function
REQ-006 SHALL accept an access only when chipselect=1; a read is read_en=1, a write is write_en=1.
REQ-007 SHALL use this register map:
- 0x00 TX_DATA, write only.
- 0x04 TX_START, write only.
- 0x08 STATUS, read only: bit0 err, bit1 tx_ready, bits[15:8] rx_level.
- 0x0C RX_DATA, read only.
- 0x10 IRQ_PEND, read, write-1-to-clear.
- 0x14 IRQ_MASK, read/write.
- 0x18 IRQ_FORCE, write only.
- 0x1C ERR_CLR, write only.
- 0x20+4k CFG[k], read/write.
REQ-008 SHALL present readdata exactly 1 cycle after the read strobe; readdata holds that value until the next read.
REQ-009 SHALL zero-extend every readdata field; unmapped or write-only addresses read 0; writes to unmapped or read-only addresses are ignored.
REQ-010 SHALL, on a TX_DATA write, drive tx_data=writedata[DATA_W-1:0] and tx_wren=1 for exactly the next cycle.
REQ-011 SHALL, on a TX_START write with writedata[0]=1 and tx_ready=1, pulse tx_start for 1 cycle in the next cycle.
REQ-012 SHALL, on a TX_START write with writedata[0]=1 and tx_ready=0, produce no pulse and set err.
REQ-013 SHALL, on an RX_DATA read with rx_level!=0, capture rx_data in the strobe cycle and pulse rx_rden for 1 cycle in the next cycle.
REQ-014 SHALL, on an RX_DATA read with rx_level=0, return 0, produce no rx_rden pulse and set err.
REQ-015 SHALL keep err sticky until an ERR_CLR write with writedata[0]=1; if a new error and the clear occur in the same cycle, err SHALL remain set.
REQ-016 SHALL set pend[i] on a rising edge of irq_src[i], detected against a 1-cycle registered copy of irq_src.
REQ-017 SHALL clear pend[i] on an IRQ_PEND write with writedata[i]=1.
REQ-018 SHALL set pend[i] on an IRQ_FORCE write with writedata[i]=1.
REQ-019 SHALL let a set of pend[i] (edge or force) win over a same-cycle clear.
REQ-020 SHALL register irq = |(pend & mask), so irq follows pend/mask changes 1 cycle later; pend SHALL record edges regardless of mask.
REQ-021 SHALL treat read_en and write_en asserted together as a write only; readdata SHALL then load 0 and no read side effect (rx_rden) SHALL occur.
REQ-022 SHALL ignore writedata bits above IRQ_N for the IRQ registers.

Reset
REQ-023 SHALL, while reset=1, clear readdata, tx_data, tx_wren, tx_start, rx_rden, irq, err, pend and mask, and load cfg from CFG_INIT.
REQ-024 SHALL, while reset=1, load the irq_src edge register with the current irq_src, so sources already high at reset release set no pending bit.
REQ-025 SHALL abort any pulse scheduled in the cycle before reset, so that no tx_wren, tx_start or rx_rden pulse occurs after reset asserts.

Structure
REQ-026 SHALL place the register offsets, STATUS bit positions and the err-source enum in a package named hps_mailbox_pkg.
REQ-027 SHALL implement the edge detect, pend, mask and irq logic in one sub-module named hps_irq_ctrl, parametrised by IRQ_N.

Verification
REQ-028 SHALL cover: write 0x00=0x1A5 with DATA_W=8 -> tx_data=0xA5, tx_wren high for exactly 1 cycle.
REQ-029 SHALL cover: tx_ready=0, write 0x04=1 -> no tx_start, STATUS reads 0x1; then write 0x1C=1, tx_ready=1, write 0x04=1 -> one tx_start pulse, STATUS reads 0x2.
REQ-030 SHALL cover: rx_level=3, rx_data=0x5C, read 0x0C -> readdata=0x5C next cycle, one rx_rden pulse; rx_level=0, read 0x0C -> readdata=0, no rx_rden, err=1.
REQ-031 SHALL cover: mask=0x0, rising edge on irq_src[2] -> IRQ_PEND reads 0x4, irq=0; write mask=0x4 -> irq=1 one cycle later; write 0x10=0x4 -> irq=0.
REQ-032 SHALL cover: a rising edge on irq_src[1] in the same cycle as a write 0x10=0x2 -> pend[1] stays 1.
REQ-033 SHALL cover: irq_src=0xF held through reset release -> IRQ_PEND reads 0 and every cfg[k] equals its CFG_INIT value.
